// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's serial input, the CPU fetch port and the status
//   outputs so the loader and whatever drives it share one connection.
//
//   rxd        UART receive line, idle high
//   addr       instruction fetch address from the CPU program counter
//   dout       instruction at addr, combinational read of the program RAM
//   cpu_reset  active-low reset to the CPU core (0 = CPU held)
//   loading    high while a frame is being received
//   err        sticky error flag
//
//   master : the environment side (drives rxd/addr, observes the rest)
//   slave  : the prog_loader side
interface prog_loader_if;
  logic       rxd;
  logic [3:0] addr;
  logic [7:0] dout;
  logic       cpu_reset;
  logic       loading;
  logic       err;

  modport master (
    output rxd,
    output addr,
    input  dout,
    input  cpu_reset,
    input  loading,
    input  err
  );

  modport slave (
    input  rxd,
    input  addr,
    output dout,
    output cpu_reset,
    output loading,
    output err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Program-load stage in front of the 4-bit CPU core. A UART receiver
//   collects a frame (header, 16 program bytes, checksum) into a 16x8
//   program RAM. The CPU is held in reset until a checksum-valid frame has
//   been stored. The CPU fetches from the RAM through an asynchronous read.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//     HDR_BYTE      frame header byte
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    prog_loader_if.slave: rxd, addr in; dout, cpu_reset,
//            loading, err out
module prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_HDR, LOAD, CHECK, RUN} ld_state_t;

  // ---------------------------------------------------------------------
  // rxd synchroniser; rxd_prev gives the falling-edge detector its history.
  // All three reset to the idle level so reset never fakes a start edge.
  // ---------------------------------------------------------------------
  logic rxd_meta, rxd_sync, rxd_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= bus.rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid, rx_valid_n;
  logic             frame_err, frame_err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  // The start bit is re-checked CNT_HALF+1 cycles after the edge, which
  // lands at mid-bit; every later sample is one full bit period on, so all
  // data and stop samples also fall at mid-bit. rx_shift holds the byte
  // steady while rx_valid is high because idle never shifts.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rxd_prev && !rxd_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxd_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n    = '0;
          rx_state_n  = RX_IDLE;
          rx_valid_n  = rxd_sync;
          frame_err_n = !rxd_sync;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame loader FSM
  // ---------------------------------------------------------------------
  ld_state_t  state, state_n;
  logic [3:0] index, index_n;
  logic [7:0] sum, sum_n;
  logic       err_q, err_n;
  logic       mem_we;
  logic       hdr_seen;

  assign hdr_seen = rx_valid && (rx_shift == HDR_BYTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_HDR;
      index <= '0;
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      sum   <= sum_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    sum_n   = sum;
    err_n   = err_q;
    mem_we  = 1'b0;
    unique case (state)
      WAIT_HDR, RUN: begin
        if (hdr_seen) begin
          state_n = LOAD;
          index_n = '0;
          sum_n   = '0;
          err_n   = 1'b0;
        end
      end
      LOAD: begin
        if (frame_err) begin
          state_n = WAIT_HDR;
          err_n   = 1'b1;
        end else if (rx_valid) begin
          mem_we  = 1'b1;
          sum_n   = sum + rx_shift;
          index_n = index + 4'd1;
          if (index == 4'd15) state_n = CHECK;
        end
      end
      CHECK: begin
        if (frame_err) begin
          state_n = WAIT_HDR;
          err_n   = 1'b1;
        end else if (rx_valid) begin
          if (rx_shift == sum) begin
            state_n = RUN;
          end else begin
            state_n = WAIT_HDR;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = WAIT_HDR;
    endcase
  end

  // WAIT_HDR is only ever entered from reset or an aborted frame, so the
  // CPU is released purely by being in RUN. A new header seen in RUN
  // drops cpu_reset combinationally in the same cycle.
  assign bus.cpu_reset = (state == RUN) && !hdr_seen;
  assign bus.loading   = (state == LOAD) || (state == CHECK);
  assign bus.err       = err_q;

  // ---------------------------------------------------------------------
  // Program RAM: no reset, so an aborted or reset frame keeps what it
  // already wrote. Power-up contents are zero.
  // ---------------------------------------------------------------------
  logic [7:0] mem [16] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    if (mem_we) mem[index] <= rx_shift;
  end

  assign bus.dout = mem[bus.addr];

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader with a short UART bit time.
//   Program bytes are pushed to a scoreboard queue as they are sent and
//   popped against dout once the frame has finished.
module tb_prog_loader;
  localparam int         CPB = 4;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  logic [7:0] model_mem [16];

  prog_loader_if bus ();

  prog_loader #(.CLKS_PER_BIT(CPB), .HDR_BYTE(HDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Serialise one byte LSB first, then leave the line idle for two bits.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_prog_byte(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
    model_mem[a] = d;
    send_byte(d, 1'b1);
  endtask

  task automatic send_program(input logic [7:0] base, input logic [7:0] step,
                              output logic [7:0] csum);
    logic [7:0] d;
    d = base;
    csum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      send_prog_byte(4'(i), d);
      csum = csum + d;
      d = d + step;
    end
  endtask

  // Returns at the negedge where the receiver's byte strobe is high.
  task automatic wait_rx_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 * CPB && !seen; i++) begin
      @(negedge clk);
      if (dut.rx_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.rxd = 1'b1;
    bus.addr = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_reset: got %b expected 0", bus.cpu_reset); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL reset_loading: got %b expected 0", bus.loading); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    reset = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL idle_cpu_reset: got %b expected 0", bus.cpu_reset); end
    for (int i = 0; i < 16; i++) begin
      bus.addr = 4'(i);
      #1;
      checks++; if (bus.dout !== model_mem[i]) begin errors++; $display("[TB] FAIL powerup_dout[%0d]: got %h expected %h", i, bus.dout, model_mem[i]); end
    end
  endtask

  task automatic test_load();
    logic [7:0] csum;
    bit seen;
    wr_t e;
    send_byte(HDR, 1'b1);
    checks++; if (bus.loading !== 1'b1) begin errors++; $display("[TB] FAIL load_loading: got %b expected 1", bus.loading); end
    send_program(8'h00, 8'h01, csum);
    fork
      send_byte(8'h78, 1'b1);
      begin
        wait_rx_valid(seen);
        checks++;
        if (!seen) begin
          errors++; $display("[TB] FAIL load_rx_valid: got timeout expected strobe");
        end else begin
          if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL load_release_early: got %b expected 0", bus.cpu_reset); end
          @(negedge clk);
          checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL load_release: got %b expected 1", bus.cpu_reset); end
        end
      end
    join
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL load_err: got %b expected 0", bus.err); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL load_loading_done: got %b expected 0", bus.loading); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL load_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] csum;
    wr_t e;
    send_byte(HDR, 1'b1);
    send_program(8'h00, 8'h01, csum);
    send_byte(8'h79, 1'b1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL badsum_err: got %b expected 1", bus.err); end
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL badsum_cpu_reset: got %b expected 0", bus.cpu_reset); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL badsum_loading: got %b expected 0", bus.loading); end
    exp_q.delete();
    send_byte(8'h5A, 1'b1);
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL badsum_ignore_loading: got %b expected 0", bus.loading); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL badsum_err_sticky: got %b expected 1", bus.err); end
    send_byte(HDR, 1'b1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL resend_err_clear: got %b expected 0", bus.err); end
    checks++; if (bus.loading !== 1'b1) begin errors++; $display("[TB] FAIL resend_loading: got %b expected 1", bus.loading); end
    send_program(8'h00, 8'h01, csum);
    send_byte(8'h78, 1'b1);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL resend_release: got %b expected 1", bus.cpu_reset); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL resend_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] csum;
    wr_t e;
    send_byte(HDR, 1'b1);
    send_program(8'hFF, 8'h00, csum);
    send_byte(8'hF0, 1'b1);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL wrap_release: got %b expected 1", bus.cpu_reset); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err: got %b expected 0", bus.err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL wrap_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
  endtask

  // Leaves the FSM in LOAD; test_framing_error continues this frame.
  task automatic test_run_restart();
    bit seen;
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart_pre: got %b expected 1", bus.cpu_reset); end
    fork
      send_byte(HDR, 1'b1);
      begin
        wait_rx_valid(seen);
        checks++;
        if (!seen) begin
          errors++; $display("[TB] FAIL restart_rx_valid: got timeout expected strobe");
        end else begin
          if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL restart_drop: got %b expected 0", bus.cpu_reset); end
          @(negedge clk);
          checks++; if (bus.loading !== 1'b1) begin errors++; $display("[TB] FAIL restart_loading: got %b expected 1", bus.loading); end
        end
      end
    join
  endtask

  task automatic test_framing_error();
    wr_t e;
    for (int i = 0; i < 4; i++) send_prog_byte(4'(i), 8'(8'h10 * (i + 1)));
    send_byte(8'h55, 1'b0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL frame_err: got %b expected 1", bus.err); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL frame_loading: got %b expected 0", bus.loading); end
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL frame_cpu_reset: got %b expected 0", bus.cpu_reset); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL frame_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
    for (int i = 4; i < 16; i++) begin
      bus.addr = 4'(i);
      #1;
      checks++; if (bus.dout !== model_mem[i]) begin errors++; $display("[TB] FAIL frame_kept[%0d]: got %h expected %h", i, bus.dout, model_mem[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] csum;
    wr_t e;
    send_byte(HDR, 1'b1);
    for (int i = 0; i < 7; i++) send_prog_byte(4'(i), 8'(8'hC0 + i));
    // Start of the 8th byte: start bit and three data bits, then reset.
    @(negedge clk) bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rxd = i[0];
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b0;
    bus.rxd = 1'b1;
    #1;
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cpu_reset: got %b expected 0", bus.cpu_reset); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL midrst_loading: got %b expected 0", bus.loading); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle_loading: got %b expected 0", bus.loading); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle_err: got %b expected 0", bus.err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL midrst_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
    for (int i = 7; i < 16; i++) begin
      bus.addr = 4'(i);
      #1;
      checks++; if (bus.dout !== model_mem[i]) begin errors++; $display("[TB] FAIL midrst_kept[%0d]: got %h expected %h", i, bus.dout, model_mem[i]); end
    end
    send_byte(HDR, 1'b1);
    checks++; if (bus.loading !== 1'b1) begin errors++; $display("[TB] FAIL reload_loading: got %b expected 1", bus.loading); end
    send_program(8'h3C, 8'h11, csum);
    send_byte(csum, 1'b1);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL reload_release: got %b expected 1", bus.cpu_reset); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reload_err: got %b expected 0", bus.err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.addr = e.a;
      #1;
      checks++; if (bus.dout !== e.d) begin errors++; $display("[TB] FAIL reload_mem[%0d]: got %h expected %h", e.a, bus.dout, e.d); end
    end
  endtask

  task automatic test_glitch();
    int strobes;
    strobes = 0;
    @(negedge clk) bus.rxd = 1'b0;
    @(negedge clk) bus.rxd = 1'b1;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (dut.rx_valid === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL glitch_strobes: got %0d expected 0", strobes); end
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL glitch_cpu_reset: got %b expected 1", bus.cpu_reset); end
    checks++; if (bus.loading !== 1'b0) begin errors++; $display("[TB] FAIL glitch_loading: got %b expected 0", bus.loading); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL glitch_err: got %b expected 0", bus.err); end
  endtask

  initial begin
    $display("[TB] starting prog_loader bench");
    test_reset();
    test_load();
    test_bad_checksum();
    test_wrap();
    test_run_restart();
    test_framing_error();
    test_mid_reset();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-load stage directly upstream of the 4-bit CPU core.
- Replaces the CPU's fixed instruction ROM with a 16x8 program RAM filled over a UART serial line.
- Presents the same asynchronous read port the core fetches from (4-bit address in, 8-bit instruction out).
- Holds the core in reset through its active-low reset input until a complete, checksum-valid program has been received.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200); minimum value 4.
- HDR_BYTE, 8'hA5: frame header byte.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rxd  input  1  UART receive line, idle high, asynchronous to clk.
- addr  input  4  instruction fetch address (the CPU's PC).
- dout  output  8  instruction at addr; combinational read of program RAM.
- cpu_reset  output  1  active-low reset to the CPU core; 0 = hold the CPU.
- loading  output  1  high while a frame is being received.
- err  output  1  sticky error flag; cleared by the next valid header or by reset.

Behaviour:
- Reset values: cpu_reset=0, loading=0, err=0, FSM in WAIT_HDR.
- The RAM is not cleared by reset. Power-up contents are all 8'h00.
- dout = mem[addr] at all times, including during loading.

UART receiver:
- Two-flop synchroniser on rxd.
- Start is detected on a falling edge of synchronised rxd, then re-checked low at mid-bit (CLKS_PER_BIT/2). If it is high at mid-bit, the start is a glitch: return to idle with no error.
- 8 data bits LSB first, each sampled at mid-bit.
- Stop bit sampled at mid-bit:
  - 1: pulse rx_valid for one cycle with rx_byte.
  - 0: framing error; the byte is discarded.
- The receiver returns to idle immediately after the stop sample.

Frame format: HDR_BYTE, 16 program bytes (address 0..15 in order), then a checksum byte equal to the sum of the 16 program bytes mod 256.

FSM states:
- WAIT_HDR:
  - cpu_reset keeps its prior value; it is 0 after reset or error.
  - A valid byte equal to HDR_BYTE goes to LOAD: index=0, sum=0, err=0, cpu_reset=0, loading=1.
  - Any other byte is ignored.
- LOAD:
  - Each valid byte is written to mem[index] in the rx_valid cycle.
  - sum += byte, index += 1.
  - After index 15 is written, go to CHECK.
- CHECK: the next valid byte is compared with sum.
  - Equal: go to RUN, loading=0, and cpu_reset=1 on the following clk edge.
  - Not equal: err=1, loading=0, cpu_reset stays 0, go to WAIT_HDR.
- RUN:
  - cpu_reset=1.
  - A valid HDR_BYTE starts a new frame: cpu_reset=0 in the same cycle, go to LOAD.
  - Other bytes are ignored.

Error and boundary rules:
- A framing error in LOAD or CHECK aborts the frame: err=1, loading=0, go to WAIT_HDR, cpu_reset held 0.
- A framing error in WAIT_HDR or RUN is ignored.
- A partially written RAM after an abort is never released to the CPU.
- index is 4 bits. Wrap after 15 is not used because the FSM leaves LOAD at that point.
- sum is 8 bits and wraps modulo 256.
- Asserting reset mid-frame:
  - FSM returns to WAIT_HDR, cpu_reset=0.
  - The receiver returns to idle, and bits of the current byte are discarded.
  - RAM contents already written are kept.
- There is no frame timeout; a stalled frame waits indefinitely with the CPU held.

Test Plan:
- Reset, then idle line. Expect cpu_reset=0, loading=0, err=0, and dout=8'h00 for all 16 addr.
- CLKS_PER_BIT=4. Send A5, bytes 00..0F, checksum 8'h78. Expect:
  - loading high after A5.
  - mem[i]=i, readable on dout.
  - cpu_reset rises exactly one clk after the checksum byte's rx_valid; err=0.
- Same frame with checksum 8'h79. Expect err=1, cpu_reset stays 0, state WAIT_HDR. Resending the correct frame clears err and releases the CPU.
- Frame of sixteen 8'hFF bytes with checksum 8'hF0 (mod-256 wrap). Expect release. Then in RUN, send A5. Expect cpu_reset to drop in the rx_valid cycle and loading=1.
- Stop bit forced 0 on the 5th program byte. Expect err=1, loading=0, cpu_reset=0, and mem[0..3] updated.
- Mid-frame: pulse reset low for 2 cycles during the 8th program byte. Expect immediate cpu_reset=0, loading=0, receiver idle; the next A5 frame loads correctly.
- rxd low pulse of one cycle only. Expect no rx_valid and no state change.
